rb_writeback_arbiter: RTL and testbench
=======================================

// Module: rb_writeback_arbiter
// PURPOSE
//  Writeback stage directly upstream of register_block: accepts per-warp, per-lane results from
//  the ALU and LSU pipes, buffers each source in a small FIFO and drives register_block's single
//  write port (write_en/waddr/wdata_0..7/warp_selector), at most one register write per cycle.
//  Round-robin between sources; per-source order preserved.
// PARAMETERS
//  NUM_LANES   8   lanes per warp; fixed at 8 (matches wdata_0..wdata_7 port set)
//  NUM_REGS    32  registers per lane; waddr width = $clog2(NUM_REGS) = 5
//  NUM_WARPS   8   warps; warp width = $clog2(NUM_WARPS) = 3
//  DATA_W      32  register width
//  FIFO_DEPTH  2   entries per source FIFO, >=1
// PORTS
//  clk            in   1      clock, all state on posedge
//  rst_n          in   1      asynchronous active-low reset
//  alu_valid      in   1      ALU result valid
//  alu_ready      out  1      ALU FIFO not full
//  alu_warp       in   3      destination warp
//  alu_rd         in   5      destination register
//  alu_mask       in   8      lane write mask, bit i -> lane i
//  alu_data       in   256    lane i data = alu_data[32*i +: 32]
//  lsu_valid/lsu_ready/lsu_warp/lsu_rd/lsu_mask/lsu_data   same as ALU set, LSU source
//  write_en       out  8      to register_block.write_en
//  waddr          out  5      to register_block.waddr
//  warp_selector  out  3      to register_block.warp_selector
//  wdata_0..7     out  32 ea  to register_block.wdata_0..wdata_7
//  wb_active      out  1      =|write_en; core top gives writeback priority on warp_selector
// BEHAVIOUR
//  - Reset (async, rst_n=0): FIFOs empty, write_en=0, waddr=0, warp_selector=0, wdata_*=0,
//    last_grant=LSU (ALU wins first tie). alu_ready/lsu_ready=1 once out of reset.
//  - Enqueue: src_valid && src_ready at posedge pushes {warp,rd,mask,data}. src_ready = !full,
//    decoded from the FIFO count register only (no combinational path from valid or pop).
//  - Dequeue/arbitration each posedge: neither FIFO non-empty -> write_en<=0, other outputs hold.
//    One non-empty -> pop it. Both -> pop source != last_grant; last_grant updates on every pop.
//    Popped entry registered: write_en<=mask, waddr<=rd, warp_selector<=warp, wdata_i<=lane i.
//  - Latency: accepted at edge N -> on outputs after edge N+1 -> written into register_block at
//    edge N+2 (uncontended). Throughput 1 write/cycle total.
//  - mask=0 entry: still popped, consumes its slot, write_en=0 that cycle.
//  - Full FIFO: ready low; simultaneous pop at that edge frees a slot, ready high next cycle.
//    Valid while !ready is not accepted; source holds. Push+pop same edge leaves count unchanged.
//  - Ordering: FIFO order kept per source; no cross-source same-{warp,rd} ordering (issue
//    scoreboard guarantees exclusivity). No register-0 special case.
//  - Pointers wrap modulo FIFO_DEPTH; count width $clog2(FIFO_DEPTH+1).
//  - Reset mid-operation: queued writes discarded, outputs return to reset values immediately.
// STRUCTURE
//  - Shared package rb_pkg: LANES/REGS/WARPS/DATA_W constants, wb_req_t struct
//    {warp[2:0], rd[4:0], mask[7:0], data[8][32]}, src_e enum {SRC_ALU, SRC_LSU}.
//  - Sub-module rb_wb_fifo (parameterised depth, wb_req_t payload, push/pop/full/empty/count),
//    instanced once per source; arbiter + output registers in this module.
// TESTING
//  1 Reset: rst_n low mid-sim -> write_en=00, waddr=00, warp_selector=0, wdata_*=0, readies=1.
//  2 ALU warp=3 rd=05 mask=FF data lane i=32'hA000_000i at edge N -> after N+1 write_en=FF,
//    waddr=05, warp_selector=3, wdata_i=A000_000i; read back via register_block port 0.
//  3 ALU and LSU both valid same edge -> ALU write first, LSU next cycle; repeated ties alternate.
//  4 Both push every cycle, 10 entries each (random data) -> readies drop when FIFOs fill; all 20
//    writes appear, per-source order intact, no loss; register_block contents match scoreboard.
//  5 LSU mask=0F, prior value 0 -> write_en=0F; lanes 0-3 updated, lanes 4-7 remain 0.
//  6 Push 2 ALU entries, assert rst_n=0 before drain -> write_en=00, neither write appears later.

Source files
------------

// File: rtl/rb_pkg.sv
// Shared definitions for the register-block writeback path: geometry constants,
// the queued write request format and the source identifiers used by the arbiter.
package rb_pkg;

    localparam int LANES  = 8;
    localparam int REGS   = 32;
    localparam int WARPS  = 8;
    localparam int DATA_W = 32;

    localparam int REG_W  = $clog2(REGS);
    localparam int WARP_W = $clog2(WARPS);

    // One pending register write: destination warp/register, per-lane enable mask
    // and the eight lane values (lane i lives in data[i]).
    typedef struct packed {
        logic [WARP_W-1:0]            warp;
        logic [REG_W-1:0]             rd;
        logic [LANES-1:0]             mask;
        logic [LANES-1:0][DATA_W-1:0] data;
    } wb_req_t;

    // Result producers feeding the writeback port.
    typedef enum logic {
        SRC_ALU = 1'b0,
        SRC_LSU = 1'b1
    } src_e;

endpackage

// File: rtl/rb_wb_fifo.sv
// Small circular FIFO holding pending writeback requests for one result source.
// full/empty/count all come straight from the count register, so the upstream
// ready never depends combinationally on this cycle's push or pop.
module rb_wb_fifo
    import rb_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  wb_req_t          push_data,
    input  logic             pop,
    output wb_req_t          pop_data,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

    wb_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    // Pointers wrap at DEPTH rather than at a power of two.
    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
        return (ptr == LAST_PTR) ? '0 : ptr + 1'b1;
    endfunction

    assign full     = (count == CNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    // Payload storage needs no reset; only the pointers and count define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together leave count unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= next_ptr(wr_ptr);
            end
            if (do_pop) begin
                rd_ptr <= next_ptr(rd_ptr);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/rb_writeback_arbiter.sv
// Writeback stage in front of register_block: buffers ALU and LSU results in one
// FIFO each and drives the single register write port, at most one write per cycle,
// alternating between sources when both have work queued.
module rb_writeback_arbiter
    import rb_pkg::*;
#(
    parameter int FIFO_DEPTH = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,

    input  logic                      alu_valid,
    output logic                      alu_ready,
    input  logic [WARP_W-1:0]         alu_warp,
    input  logic [REG_W-1:0]          alu_rd,
    input  logic [LANES-1:0]          alu_mask,
    input  logic [LANES*DATA_W-1:0]   alu_data,

    input  logic                      lsu_valid,
    output logic                      lsu_ready,
    input  logic [WARP_W-1:0]         lsu_warp,
    input  logic [REG_W-1:0]          lsu_rd,
    input  logic [LANES-1:0]          lsu_mask,
    input  logic [LANES*DATA_W-1:0]   lsu_data,

    output logic [LANES-1:0]          write_en,
    output logic [REG_W-1:0]          waddr,
    output logic [WARP_W-1:0]         warp_selector,
    output logic [DATA_W-1:0]         wdata_0,
    output logic [DATA_W-1:0]         wdata_1,
    output logic [DATA_W-1:0]         wdata_2,
    output logic [DATA_W-1:0]         wdata_3,
    output logic [DATA_W-1:0]         wdata_4,
    output logic [DATA_W-1:0]         wdata_5,
    output logic [DATA_W-1:0]         wdata_6,
    output logic [DATA_W-1:0]         wdata_7,
    output logic                      wb_active
);

    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);

    wb_req_t    alu_req;
    wb_req_t    lsu_req;
    wb_req_t    alu_head;
    wb_req_t    lsu_head;
    logic       alu_full;
    logic       lsu_full;
    logic       alu_empty;
    logic       lsu_empty;
    logic [CNT_W-1:0] alu_count;
    logic [CNT_W-1:0] lsu_count;
    logic       alu_push;
    logic       lsu_push;
    logic       alu_pop;
    logic       lsu_pop;
    src_e       last_grant;

    logic [LANES-1:0][DATA_W-1:0] wdata_q;

    // Field order of the packed struct matches this concatenation.
    assign alu_req = {alu_warp, alu_rd, alu_mask, alu_data};
    assign lsu_req = {lsu_warp, lsu_rd, lsu_mask, lsu_data};

    // Ready is decoded from the registered occupancy only.
    assign alu_ready = (alu_count != CNT_W'(FIFO_DEPTH));
    assign lsu_ready = (lsu_count != CNT_W'(FIFO_DEPTH));
    assign alu_push  = alu_valid && !alu_full;
    assign lsu_push  = lsu_valid && !lsu_full;

    // A lone non-empty source always wins; on a tie the source not granted last goes.
    assign alu_pop = !alu_empty && (lsu_empty || (last_grant == SRC_LSU));
    assign lsu_pop = !lsu_empty && (alu_empty || (last_grant == SRC_ALU));

    rb_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_alu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (alu_push),
        .push_data (alu_req),
        .pop       (alu_pop),
        .pop_data  (alu_head),
        .full      (alu_full),
        .empty     (alu_empty),
        .count     (alu_count)
    );

    rb_wb_fifo #(.DEPTH(FIFO_DEPTH)) u_lsu_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (lsu_push),
        .push_data (lsu_req),
        .pop       (lsu_pop),
        .pop_data  (lsu_head),
        .full      (lsu_full),
        .empty     (lsu_empty),
        .count     (lsu_count)
    );

    // Register the popped entry onto the write port; idle cycles drop write_en and hold the rest.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            write_en      <= '0;
            waddr         <= '0;
            warp_selector <= '0;
            wdata_q       <= '0;
            last_grant    <= SRC_LSU;
        end else if (alu_pop) begin
            write_en      <= alu_head.mask;
            waddr         <= alu_head.rd;
            warp_selector <= alu_head.warp;
            wdata_q       <= alu_head.data;
            last_grant    <= SRC_ALU;
        end else if (lsu_pop) begin
            write_en      <= lsu_head.mask;
            waddr         <= lsu_head.rd;
            warp_selector <= lsu_head.warp;
            wdata_q       <= lsu_head.data;
            last_grant    <= SRC_LSU;
        end else begin
            write_en      <= '0;
        end
    end

    assign wdata_0 = wdata_q[0];
    assign wdata_1 = wdata_q[1];
    assign wdata_2 = wdata_q[2];
    assign wdata_3 = wdata_q[3];
    assign wdata_4 = wdata_q[4];
    assign wdata_5 = wdata_q[5];
    assign wdata_6 = wdata_q[6];
    assign wdata_7 = wdata_q[7];

    assign wb_active = |write_en;

endmodule

// File: tb/tb_rb_writeback_arbiter.sv
// Directed bench for rb_writeback_arbiter: a behavioural register_block model
// captures every write seen on the port and is compared with hand-built expectations.
module tb_rb_writeback_arbiter;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         alu_valid, alu_ready;
    logic [2:0]   alu_warp;
    logic [4:0]   alu_rd;
    logic [7:0]   alu_mask;
    logic [255:0] alu_data;
    logic         lsu_valid, lsu_ready;
    logic [2:0]   lsu_warp;
    logic [4:0]   lsu_rd;
    logic [7:0]   lsu_mask;
    logic [255:0] lsu_data;
    logic [7:0]   write_en;
    logic [4:0]   waddr;
    logic [2:0]   warp_selector;
    logic [31:0]  wdata_0, wdata_1, wdata_2, wdata_3, wdata_4, wdata_5, wdata_6, wdata_7;
    logic         wb_active;
    logic [255:0] wdata_all;

    int n_checks = 0;
    int n_pass   = 0;

    typedef struct packed {
        logic [2:0]   warp;
        logic [4:0]   rd;
        logic [7:0]   mask;
        logic [255:0] data;
    } ent_t;

    ent_t        wlog [$];
    logic [31:0] rf [8][32][8];
    bit          saw_alu_full;
    bit          saw_lsu_full;

    always #5 clk = ~clk;

    assign wdata_all = {wdata_7, wdata_6, wdata_5, wdata_4, wdata_3, wdata_2, wdata_1, wdata_0};

    rb_writeback_arbiter #(.FIFO_DEPTH(2)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .alu_valid     (alu_valid),
        .alu_ready     (alu_ready),
        .alu_warp      (alu_warp),
        .alu_rd        (alu_rd),
        .alu_mask      (alu_mask),
        .alu_data      (alu_data),
        .lsu_valid     (lsu_valid),
        .lsu_ready     (lsu_ready),
        .lsu_warp      (lsu_warp),
        .lsu_rd        (lsu_rd),
        .lsu_mask      (lsu_mask),
        .lsu_data      (lsu_data),
        .write_en      (write_en),
        .waddr         (waddr),
        .warp_selector (warp_selector),
        .wdata_0       (wdata_0),
        .wdata_1       (wdata_1),
        .wdata_2       (wdata_2),
        .wdata_3       (wdata_3),
        .wdata_4       (wdata_4),
        .wdata_5       (wdata_5),
        .wdata_6       (wdata_6),
        .wdata_7       (wdata_7),
        .wb_active     (wb_active)
    );

    // register_block model: each write on the port lands at the next edge; sampled mid-cycle.
    always @(negedge clk) begin
        if (rst_n && write_en != 8'h00) begin
            wlog.push_back({warp_selector, waddr, write_en, wdata_all});
            for (int l = 0; l < 8; l++) begin
                if (write_en[l]) rf[warp_selector][waddr][l] = wdata_all[32*l +: 32];
            end
        end
        if (rst_n && !alu_ready) saw_alu_full = 1'b1;
        if (rst_n && !lsu_ready) saw_lsu_full = 1'b1;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges and clear the bench-side history.
    task automatic reset_pulse();
        rst_n = 1'b0;
        #2;
        wlog.delete();
        rst_n = 1'b1;
        step();
    endtask

    // Hold an ALU request until an edge where ready was high; called #1 after a posedge.
    task automatic alu_send(input logic [2:0] w, input logic [4:0] r,
                            input logic [7:0] m, input logic [255:0] d);
        bit acc = 1'b0;
        int guard = 0;
        alu_valid = 1'b1; alu_warp = w; alu_rd = r; alu_mask = m; alu_data = d;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = alu_ready;
            @(posedge clk);
            guard++;
        end
        #1;
        alu_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("[TB] FAIL alu_accept_timeout: ready never seen high, required accept within 50 cycles");
        end
    endtask

    task automatic lsu_send(input logic [2:0] w, input logic [4:0] r,
                            input logic [7:0] m, input logic [255:0] d);
        bit acc = 1'b0;
        int guard = 0;
        lsu_valid = 1'b1; lsu_warp = w; lsu_rd = r; lsu_mask = m; lsu_data = d;
        while (!acc && guard < 50) begin
            @(negedge clk);
            acc = lsu_ready;
            @(posedge clk);
            guard++;
        end
        #1;
        lsu_valid = 1'b0;
        if (!acc) begin
            n_checks++;
            $display("[TB] FAIL lsu_accept_timeout: ready never seen high, required accept within 50 cycles");
        end
    endtask

    function automatic logic [255:0] lane_pattern(input logic [31:0] base);
        logic [255:0] d;
        for (int l = 0; l < 8; l++) d[32*l +: 32] = base + 32'(l);
        return d;
    endfunction

    // Outputs while reset is held low.
    task automatic test_reset();
        n_checks++;
        if (write_en !== 8'h00) $display("[TB] FAIL reset_write_en: got %h want 00", write_en);
        else n_pass++;
        n_checks++;
        if (waddr !== 5'h00) $display("[TB] FAIL reset_waddr: got %h want 00", waddr);
        else n_pass++;
        n_checks++;
        if (warp_selector !== 3'd0) $display("[TB] FAIL reset_warp: got %0d want 0", warp_selector);
        else n_pass++;
        n_checks++;
        if (wdata_all !== 256'h0) $display("[TB] FAIL reset_wdata: got %h want 0", wdata_all);
        else n_pass++;
        n_checks++;
        if ({alu_ready, lsu_ready, wb_active} !== 3'b110)
            $display("[TB] FAIL reset_ready_active: got %b want 110", {alu_ready, lsu_ready, wb_active});
        else n_pass++;
    endtask

    // One full-mask ALU write, checking the two-edge latency.
    task automatic test_single_write();
        logic [255:0] d = lane_pattern(32'hA000_0000);
        alu_send(3'd3, 5'd5, 8'hFF, d);
        @(negedge clk);
        n_checks++;
        if (write_en !== 8'h00) $display("[TB] FAIL single_latency: got write_en %h one edge after accept, want 00", write_en);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({write_en, waddr, warp_selector, wb_active} !== {8'hFF, 5'd5, 3'd3, 1'b1})
            $display("[TB] FAIL single_ctrl: got en=%h addr=%h warp=%0d act=%b want FF/05/3/1",
                     write_en, waddr, warp_selector, wb_active);
        else n_pass++;
        n_checks++;
        if (wdata_all !== d) $display("[TB] FAIL single_wdata: got %h want %h", wdata_all, d);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if (rf[3][5][0] !== 32'hA000_0000 || rf[3][5][7] !== 32'hA000_0007)
            $display("[TB] FAIL single_readback: got lane0 %h lane7 %h want A0000000/A0000007", rf[3][5][0], rf[3][5][7]);
        else n_pass++;
        n_checks++;
        if (write_en !== 8'h00) $display("[TB] FAIL single_idle: got write_en %h want 00", write_en);
        else n_pass++;
    endtask

    // Three ties in a row: grants must alternate ALU, LSU, ALU, ...
    task automatic test_tie_alternate();
        ent_t exp [6];
        reset_pulse();
        for (int k = 0; k < 3; k++) begin
            exp[2*k]     = {3'd1, 5'(k + 1),  8'hFF, lane_pattern(32'h1100_0000 + 32'(k << 8))};
            exp[2*k + 1] = {3'd2, 5'(k + 17), 8'hFF, lane_pattern(32'h2200_0000 + 32'(k << 8))};
        end
        fork
            for (int k = 0; k < 3; k++) alu_send(exp[2*k].warp, exp[2*k].rd, exp[2*k].mask, exp[2*k].data);
            for (int k = 0; k < 3; k++) lsu_send(exp[2*k+1].warp, exp[2*k+1].rd, exp[2*k+1].mask, exp[2*k+1].data);
        join
        repeat (8) step();
        n_checks++;
        if (wlog.size() != 6) $display("[TB] FAIL tie_count: got %0d writes want 6", wlog.size());
        else n_pass++;
        for (int k = 0; k < 6; k++) begin
            n_checks++;
            if (k >= wlog.size() || wlog[k] !== exp[k])
                $display("[TB] FAIL tie_order_%0d: got warp/rd %0d/%0d want %0d/%0d", k,
                         (k < wlog.size()) ? wlog[k].warp : 3'd0, (k < wlog.size()) ? wlog[k].rd : 5'd0,
                         exp[k].warp, exp[k].rd);
            else n_pass++;
        end
    endtask

    // Both sources stream 10 entries each; FIFOs fill, nothing is lost or reordered.
    task automatic test_back_to_back();
        ent_t ea [10];
        ent_t el [10];
        ent_t ga [$];
        ent_t gl [$];
        reset_pulse();
        saw_alu_full = 1'b0;
        saw_lsu_full = 1'b0;
        for (int k = 0; k < 10; k++) begin
            logic [255:0] da, dl;
            for (int l = 0; l < 8; l++) begin
                da[32*l +: 32] = $urandom;
                dl[32*l +: 32] = $urandom;
            end
            ea[k] = {3'd1, 5'(k),      8'hFF, da};
            el[k] = {3'd5, 5'(k + 16), 8'hFF, dl};
        end
        fork
            for (int k = 0; k < 10; k++) alu_send(ea[k].warp, ea[k].rd, ea[k].mask, ea[k].data);
            for (int k = 0; k < 10; k++) lsu_send(el[k].warp, el[k].rd, el[k].mask, el[k].data);
        join
        repeat (10) step();
        foreach (wlog[i]) begin
            if (wlog[i].warp == 3'd1) ga.push_back(wlog[i]);
            else gl.push_back(wlog[i]);
        end
        n_checks++;
        if (wlog.size() != 20 || ga.size() != 10)
            $display("[TB] FAIL b2b_count: got %0d total %0d alu want 20/10", wlog.size(), ga.size());
        else n_pass++;
        n_checks++;
        if (!(saw_alu_full && saw_lsu_full))
            $display("[TB] FAIL b2b_ready_drop: got alu_full_seen=%b lsu_full_seen=%b want 1/1", saw_alu_full, saw_lsu_full);
        else n_pass++;
        for (int k = 0; k < 10; k++) begin
            n_checks++;
            if (k >= ga.size() || ga[k] !== ea[k] || k >= gl.size() || gl[k] !== el[k])
                $display("[TB] FAIL b2b_order_%0d: entry differs from required alu rd %0d lsu rd %0d", k, ea[k].rd, el[k].rd);
            else n_pass++;
            n_checks++;
            if (rf[1][k][4] !== ea[k].data[128 +: 32] || rf[5][k + 16][6] !== el[k].data[192 +: 32])
                $display("[TB] FAIL b2b_regfile_%0d: got %h/%h want %h/%h", k, rf[1][k][4], rf[5][k + 16][6],
                         ea[k].data[128 +: 32], el[k].data[192 +: 32]);
            else n_pass++;
        end
    endtask

    // Partial mask writes only low lanes; a zero mask still consumes a slot.
    task automatic test_partial_mask();
        reset_pulse();
        for (int l = 0; l < 8; l++) rf[6][7][l] = 32'h0;
        lsu_send(3'd6, 5'd7, 8'h0F, lane_pattern(32'hB000_0000));
        @(negedge clk);
        @(negedge clk);
        n_checks++;
        if (write_en !== 8'h0F || wb_active !== 1'b1)
            $display("[TB] FAIL mask_write_en: got %h act %b want 0F/1", write_en, wb_active);
        else n_pass++;
        @(negedge clk);
        for (int l = 0; l < 8; l++) begin
            logic [31:0] want;
            want = (l < 4) ? 32'hB000_0000 + 32'(l) : 32'h0;
            n_checks++;
            if (rf[6][7][l] !== want) $display("[TB] FAIL mask_lane_%0d: got %h want %h", l, rf[6][7][l], want);
            else n_pass++;
        end
        step();
        alu_send(3'd2, 5'd9,  8'h00, lane_pattern(32'hC000_0000));
        alu_send(3'd2, 5'd10, 8'hFF, lane_pattern(32'hD000_0000));
        @(negedge clk);
        n_checks++;
        if ({write_en, waddr, wb_active} !== {8'h00, 5'd9, 1'b0})
            $display("[TB] FAIL mask_zero_slot: got en=%h addr=%h act=%b want 00/09/0", write_en, waddr, wb_active);
        else n_pass++;
        @(negedge clk);
        n_checks++;
        if ({write_en, waddr} !== {8'hFF, 5'd10})
            $display("[TB] FAIL mask_zero_next: got en=%h addr=%h want FF/0A", write_en, waddr);
        else n_pass++;
    endtask

    // Reset while two ALU entries are queued: outputs clear at once, no later writes.
    task automatic test_reset_mid();
        reset_pulse();
        alu_send(3'd4, 5'd12, 8'hFF, lane_pattern(32'hE000_0000));
        alu_send(3'd4, 5'd13, 8'hFF, lane_pattern(32'hF000_0000));
        #1;
        rst_n = 1'b0;
        #1;
        test_reset();
        wlog.delete();
        rst_n = 1'b1;
        repeat (6) step();
        n_checks++;
        if (wlog.size() != 0) $display("[TB] FAIL reset_mid_discard: got %0d writes want 0", wlog.size());
        else n_pass++;
    endtask

    initial begin
        rst_n = 1'b0;
        alu_valid = 1'b0; alu_warp = '0; alu_rd = '0; alu_mask = '0; alu_data = '0;
        lsu_valid = 1'b0; lsu_warp = '0; lsu_rd = '0; lsu_mask = '0; lsu_data = '0;
        saw_alu_full = 1'b0;
        saw_lsu_full = 1'b0;
        for (int w = 0; w < 8; w++)
            for (int r = 0; r < 32; r++)
                for (int l = 0; l < 8; l++) rf[w][r][l] = 32'h0;
        #3;
        test_reset();
        #10;
        rst_n = 1'b1;
        step();
        test_single_write();
        test_tie_alternate();
        test_back_to_back();
        test_partial_mask();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
